ddr4_mc_port_sched: RTL and testbench

Four-port command scheduler in the DDR4 memory-controller front end. It arbitrates request lines from four command queues and issues a registered one-hot grant under a valid/ready handshake to the command issue stage. It layers three features on top of plain round-robin: urgent priority, bounded same-port bursting and age-based starvation escalation.

---
 rtl/ddr4_mc_sched_pkg.sv | 37 +++
 rtl/ddr4_mc_rr_pick.sv | 14 +
 rtl/ddr4_mc_port_sched.sv | 168 ++++++++++++++++
 tb/tb_ddr4_mc_port_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_mc_sched_pkg.sv
// Shared types and helpers for the DDR4 controller port scheduler.
// rr_first returns the first set bit of vec, searching from ptr+1 upward (mod NPORT).
package ddr4_mc_sched_pkg;

    localparam int NPORT = 4;
    localparam int PTR_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    typedef enum logic [1:0] {
        LVL_NORM   = 2'd0,
        LVL_URG    = 2'd1,
        LVL_STARVE = 2'd2
    } sched_level_e;

    function automatic logic [NPORT-1:0] rr_first(input logic [NPORT-1:0] vec,
                                                  input logic [PTR_W-1:0] ptr);
        logic [NPORT-1:0] oh;
        logic [PTR_W-1:0] idx;
        logic             found;
        oh    = '0;
        found = 1'b0;
        // k == NPORT wraps back to ptr itself, so the last-served port comes last
        for (int k = 1; k <= NPORT; k++) begin
            idx = ptr + PTR_W'(k);
            if (!found && vec[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/ddr4_mc_rr_pick.sv
// Combinational rotating-pointer one-hot picker for one priority level.
module ddr4_mc_rr_pick
    import ddr4_mc_sched_pkg::*;
(
    input  logic [NPORT-1:0] vec,
    input  logic [PTR_W-1:0] ptr,
    output logic [NPORT-1:0] pick,
    output logic             any
);

    assign pick = rr_first(vec, ptr);
    assign any  = |vec;

endmodule

// File: rtl/ddr4_mc_port_sched.sv
// Four-port command scheduler: starving > urgent > normal requesters over a
// rotating pointer, bounded same-port bursting and a registered one-hot grant.
module ddr4_mc_port_sched
    import ddr4_mc_sched_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int AGE_W     = 6,
    parameter int AGE_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_enable,
    input  logic [NPORT-1:0] req,
    input  logic [NPORT-1:0] urgent,
    output logic [NPORT-1:0] gnt,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [NPORT-1:0] starve,
    output logic             dbg_state
);

    // Handshake: gnt/gnt_valid stay stable until gnt_valid & gnt_ready, which is the
    // transfer; gnt_ready is ignored while gnt_valid is low and gnt is 0 then.

    localparam logic [3:0]       BURST_LAST = 4'(BURST_MAX - 1);
    localparam logic [AGE_W-1:0] AGE_LIM    = AGE_W'(AGE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_SAT    = '1;

    sched_state_e     state, state_d;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
    logic [3:0]       burst_cnt, burst_cnt_d;
    logic [NPORT-1:0] gnt_d;
    logic [NPORT-1:0] starve_d;
    logic [AGE_W-1:0] age_q [NPORT];
    logic [AGE_W-1:0] age_d [NPORT];

    logic             xfer;
    logic [NPORT-1:0] xfer_mask;
    logic [NPORT-1:0] vec_stv, vec_urg, vec_norm;
    logic [NPORT-1:0] pick_stv, pick_urg, pick_norm;
    logic             any_stv, any_urg, any_norm;
    sched_level_e     top_lvl;
    logic [NPORT-1:0] top_vec, win;
    logic [PTR_W-1:0] win_idx;
    logic             can_arb, burst_ok;

    assign gnt_valid = (state == GRANT);
    assign dbg_state = state;
    assign xfer      = gnt_valid & gnt_ready;
    assign xfer_mask = gnt & {NPORT{xfer}};

    // A port whose grant transfers this cycle has its age cleared now, so it no longer starves.
    assign vec_stv  = req & starve & ~xfer_mask;
    assign vec_urg  = req & urgent;
    assign vec_norm = req;

    ddr4_mc_rr_pick u_pick_stv  (.vec(vec_stv),  .ptr(rr_ptr), .pick(pick_stv),  .any(any_stv));
    ddr4_mc_rr_pick u_pick_urg  (.vec(vec_urg),  .ptr(rr_ptr), .pick(pick_urg),  .any(any_urg));
    ddr4_mc_rr_pick u_pick_norm (.vec(vec_norm), .ptr(rr_ptr), .pick(pick_norm), .any(any_norm));

    always_comb begin
        top_lvl = LVL_NORM;
        if (any_stv) begin
            top_lvl = LVL_STARVE;
        end else if (any_urg) begin
            top_lvl = LVL_URG;
        end
    end

    always_comb begin
        top_vec = vec_norm;
        win     = pick_norm;
        case (top_lvl)
            LVL_STARVE: begin
                top_vec = vec_stv;
                win     = pick_stv;
            end
            LVL_URG: begin
                top_vec = vec_urg;
                win     = pick_urg;
            end
            default: ;
        endcase
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

    assign can_arb  = cfg_enable & any_norm;
    assign burst_ok = (|(req & gnt)) && (burst_cnt < BURST_LAST) &&
                      (|(gnt & top_vec)) && ((vec_stv & ~gnt) == '0);

    always_comb begin
        state_d     = state;
        gnt_d       = gnt;
        rr_ptr_d    = rr_ptr;
        burst_cnt_d = burst_cnt;
        case (state)
            IDLE: begin
                if (can_arb) begin
                    state_d     = GRANT;
                    gnt_d       = win;
                    rr_ptr_d    = win_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (can_arb && burst_ok) begin
                        burst_cnt_d = burst_cnt + 4'd1;
                    end else if (can_arb) begin
                        gnt_d       = win;
                        rr_ptr_d    = win_idx;
                        burst_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if ((req & gnt) == '0) begin
                    // Request withdrawn before acceptance: drop the grant, ages untouched.
                    state_d     = IDLE;
                    gnt_d       = '0;
                    burst_cnt_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            if (!req[i] || xfer_mask[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_SAT) begin
                age_d[i] = age_q[i] + 1'b1;
            end else begin
                age_d[i] = age_q[i];
            end
            starve_d[i] = (age_d[i] >= AGE_LIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= PTR_W'(NPORT - 1);
            burst_cnt <= '0;
            starve    <= '0;
            for (int i = 0; i < NPORT; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            rr_ptr    <= rr_ptr_d;
            burst_cnt <= burst_cnt_d;
            starve    <= starve_d;
            for (int i = 0; i < NPORT; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ddr4_mc_port_sched.sv
// Bench for ddr4_mc_port_sched: two instances (BURST_MAX 4 and 1) sharing stimulus,
// directed vector table, hand-written corner sequences and a randomized model run.
`timescale 1ns/1ps
module tb_ddr4_mc_port_sched;

    // ---------------- clock / reset ----------------
    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       cfg_enable = 1'b0;
    logic [3:0] req        = '0;
    logic [3:0] urgent     = '0;
    logic       gnt_ready  = 1'b0;
    logic [3:0] g4, g1, s4, s1;
    logic       v4, v1, st4, st1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr4_mc_port_sched #(.BURST_MAX(4), .AGE_W(6), .AGE_LIMIT(32)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .req(req), .urgent(urgent),
        .gnt(g4), .gnt_valid(v4), .gnt_ready(gnt_ready), .starve(s4), .dbg_state(st4)
    );

    ddr4_mc_port_sched #(.BURST_MAX(1), .AGE_W(6), .AGE_LIMIT(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .req(req), .urgent(urgent),
        .gnt(g1), .gnt_valid(v1), .gnt_ready(gnt_ready), .starve(s1), .dbg_state(st1)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        req        = '0;
        urgent     = '0;
        gnt_ready  = 1'b0;
        cfg_enable = 1'b0;
        rst_n      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [3:0] rq, input logic [3:0] ug, input logic rd, input logic en);
        req        = rq;
        urgent     = ug;
        gnt_ready  = rd;
        cfg_enable = en;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rst;
        logic [3:0] rq;
        logic [3:0] ug;
        logic       rd;
        logic       en;
        logic [3:0] g4;
        logic [3:0] g1;
        logic       v;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input bit rst, input logic [3:0] rq, input logic [3:0] ug,
                           input logic rd, input logic en, input logic [3:0] e4,
                           input logic [3:0] e1, input logic ev);
        vec_t v;
        v.rst = rst; v.rq = rq; v.ug = ug; v.rd = rd; v.en = en;
        v.g4 = e4; v.g1 = e1; v.v = ev;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // Per instance: is a grant pending, which port, pointer, length of the current run.
    int m_valid [2];
    int m_port  [2];
    int m_ptr   [2];
    int m_run   [2];
    int m_age   [2][4];
    bit m_stv   [2][4];
    int bmax    [2] = '{4, 1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_port[k] = 0; m_ptr[k] = 3; m_run[k] = 0;
            for (int i = 0; i < 4; i++) begin
                m_age[k][i] = 0;
                m_stv[k][i] = 1'b0;
            end
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] rq, input logic [3:0] ug,
                              input logic rd, input logic en);
        int lvl [4];
        int top, win, p, j;
        bit xfer, others;
        p    = m_port[k];
        xfer = (m_valid[k] != 0) && rd;
        top  = -1;
        for (int i = 0; i < 4; i++) begin
            if (!rq[i]) lvl[i] = -1;
            else if (m_stv[k][i] && !(xfer && p == i)) lvl[i] = 2;
            else if (ug[i]) lvl[i] = 1;
            else lvl[i] = 0;
            if (lvl[i] > top) top = lvl[i];
        end
        win = -1;
        for (int s = 1; s <= 4; s++) begin
            j = (m_ptr[k] + s) % 4;
            if (win < 0 && top >= 0 && lvl[j] == top) win = j;
        end
        others = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != p && lvl[i] == 2) others = 1'b1;
        end
        if (m_valid[k] == 0) begin
            if (en && rq != 0) begin
                m_valid[k] = 1; m_port[k] = win; m_ptr[k] = win; m_run[k] = 1;
            end
        end else if (xfer) begin
            if (en && rq != 0) begin
                if (rq[p] && m_run[k] < bmax[k] && lvl[p] == top && !others) begin
                    m_run[k]++;
                end else begin
                    m_port[k] = win; m_ptr[k] = win; m_run[k] = 1;
                end
            end else begin
                m_valid[k] = 0;
            end
        end else if (!rq[p]) begin
            m_valid[k] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (!rq[i] || (xfer && p == i)) m_age[k][i] = 0;
            else if (m_age[k][i] < 63) m_age[k][i]++;
            m_stv[k][i] = (m_age[k][i] >= 32);
        end
    endtask

    function automatic logic [3:0] model_gnt(input int k);
        return (m_valid[k] != 0) ? 4'(1 << m_port[k]) : 4'b0000;
    endfunction

    function automatic logic [3:0] model_stv(input int k);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = m_stv[k][i];
        return s;
    endfunction

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];

    // ---------------- test ----------------
    initial begin
        logic [3:0] urg_r;
        int         last_xfer_port;

        // Reset state
        step();
        step();
        check("rst_gnt_b4", g4, 4'b0000);
        check("rst_valid_b4", v4, 1'b0);
        check("rst_starve_b4", s4, 4'b0000);
        check("rst_state_b4", st4, 1'b0);
        check("rst_gnt_b1", g1, 4'b0000);
        check("rst_valid_b1", v1, 1'b0);
        rst_n = 1'b1;

        // Round-robin with all requesting; single requester; cfg_enable; urgent.
        add_vec(1, 4'b1111, 4'b0000, 1, 1, 4'b0001, 4'b0001, 1);
        add_vec(0, 4'b1111, 4'b0000, 1, 1, 4'b0001, 4'b0010, 1);
        add_vec(0, 4'b1111, 4'b0000, 1, 1, 4'b0001, 4'b0100, 1);
        add_vec(0, 4'b1111, 4'b0000, 1, 1, 4'b0001, 4'b1000, 1);
        add_vec(0, 4'b1111, 4'b0000, 1, 1, 4'b0010, 4'b0001, 1);
        add_vec(0, 4'b1111, 4'b0000, 1, 1, 4'b0010, 4'b0010, 1);
        add_vec(0, 4'b1111, 4'b0000, 1, 1, 4'b0010, 4'b0100, 1);
        add_vec(0, 4'b1111, 4'b0000, 1, 1, 4'b0010, 4'b1000, 1);
        add_vec(0, 4'b1111, 4'b0000, 1, 1, 4'b0100, 4'b0001, 1);
        add_vec(1, 4'b0001, 4'b0000, 1, 1, 4'b0001, 4'b0001, 1);
        for (int i = 0; i < 6; i++) add_vec(0, 4'b0001, 4'b0000, 1, 1, 4'b0001, 4'b0001, 1);
        add_vec(1, 4'b0100, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        add_vec(0, 4'b0100, 4'b0000, 1, 1, 4'b0100, 4'b0100, 1);
        add_vec(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0100, 1);
        add_vec(0, 4'b0100, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        add_vec(0, 4'b0100, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        add_vec(0, 4'b0100, 4'b0000, 1, 1, 4'b0100, 4'b0100, 1);
        add_vec(1, 4'b0101, 4'b0100, 1, 1, 4'b0100, 4'b0100, 1);
        add_vec(0, 4'b0101, 4'b0100, 1, 1, 4'b0100, 4'b0100, 1);
        add_vec(0, 4'b0101, 4'b0000, 1, 1, 4'b0100, 4'b0001, 1);
        add_vec(0, 4'b0101, 4'b0000, 1, 1, 4'b0100, 4'b0100, 1);
        add_vec(0, 4'b0101, 4'b0000, 1, 1, 4'b0001, 4'b0001, 1);

        foreach (tbl[r]) begin
            if (tbl[r].rst) do_reset();
            drive(tbl[r].rq, tbl[r].ug, tbl[r].rd, tbl[r].en);
            step();
            check($sformatf("vec%0d_gnt_b4", r), g4, tbl[r].g4);
            check($sformatf("vec%0d_gnt_b1", r), g1, tbl[r].g1);
            check($sformatf("vec%0d_valid_b4", r), v4, tbl[r].v);
            check($sformatf("vec%0d_valid_b1", r), v1, tbl[r].v);
        end

        // Stall: grant held stable while ready is low, port ages into starvation.
        do_reset();
        drive(4'b0100, 4'b0000, 0, 1);
        for (int k = 0; k < 40; k++) begin
            step();
            check($sformatf("stall%0d_gnt", k), g4, 4'b0100);
            check($sformatf("stall%0d_valid", k), v4, 1'b1);
            check($sformatf("stall%0d_starve", k), s4, (k >= 31) ? 4'b0100 : 4'b0000);
        end
        gnt_ready = 1'b1;
        step();
        check("stall_xfer_gnt_b4", g4, 4'b0100);
        check("stall_xfer_gnt_b1", g1, 4'b0100);
        check("stall_xfer_starve", s4, 4'b0000);
        drive(4'b0000, 4'b0000, 0, 1);
        step();
        check("stall_drop_valid", v4, 1'b0);
        check("stall_drop_state", st4, 1'b0);

        // Withdraw before acceptance, other requester served one cycle later.
        do_reset();
        drive(4'b0011, 4'b0000, 0, 1);
        step();
        check("wd_first_gnt", g4, 4'b0001);
        req = 4'b0010;
        step();
        check("wd_valid", v4, 1'b0);
        check("wd_state", st4, 1'b0);
        check("wd_gnt", g4, 4'b0000);
        step();
        check("wd_next_gnt_b4", g4, 4'b0010);
        check("wd_next_gnt_b1", g1, 4'b0010);

        // Urgent port bursts; non-urgent port starves then preempts.
        do_reset();
        drive(4'b0011, 4'b0010, 1, 1);
        for (int k = 0; k < 32; k++) begin
            step();
            check($sformatf("stv%0d_gnt_b4", k), g4, 4'b0010);
            check($sformatf("stv%0d_gnt_b1", k), g1, 4'b0010);
            check($sformatf("stv%0d_starve", k), s4, (k >= 31) ? 4'b0001 : 4'b0000);
        end
        step();
        check("stv_pre_gnt_b4", g4, 4'b0001);
        check("stv_pre_gnt_b1", g1, 4'b0001);
        check("stv_pre_starve", s4, 4'b0001);
        step();
        check("stv_post_gnt_b4", g4, 4'b0010);
        check("stv_post_gnt_b1", g1, 4'b0010);
        check("stv_post_starve", s4, 4'b0000);

        // Asynchronous reset while a burst is in flight and a port is starving.
        do_reset();
        drive(4'b0011, 4'b0010, 1, 1);
        repeat (32) step();
        check("arst_pre_valid", v4, 1'b1);
        check("arst_pre_starve", s4, 4'b0001);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", g4, 4'b0000);
        check("arst_valid", v4, 1'b0);
        check("arst_starve", s4, 4'b0000);
        check("arst_valid_b1", v1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b1111, 4'b0000, 1, 1);
        step();
        check("arst_first_b4", g4, 4'b0001);
        check("arst_first_b1", g1, 4'b0001);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        urg_r          = '0;
        last_xfer_port = -1;
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) urg_r = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if (last_xfer_port == i) req[i] = ($urandom_range(0, 1) == 0);
                else if ($urandom_range(0, 47) == 0) req[i] = 1'b0;
            end
            urgent     = urg_r;
            gnt_ready  = ($urandom_range(0, 3) != 0);
            cfg_enable = ($urandom_range(0, 15) != 0);
            if (m_valid[0] != 0 && gnt_ready) exp_q.push_back(model_gnt(0));
            if (v4 && gnt_ready) begin
                if (exp_q.size() > 0) check("sb_xfer", g4, exp_q.pop_front());
                else check("sb_xfer_unexpected", g4, 4'b0000);
            end
            last_xfer_port = (m_valid[0] != 0 && gnt_ready) ? m_port[0] : -1;
            step();
            model_step(0, req, urgent, gnt_ready, cfg_enable);
            model_step(1, req, urgent, gnt_ready, cfg_enable);
            check("rnd_gnt_b4", g4, model_gnt(0));
            check("rnd_valid_b4", v4, (m_valid[0] != 0));
            check("rnd_starve_b4", s4, model_stv(0));
            check("rnd_state_b4", st4, (m_valid[0] != 0));
            check("rnd_gnt_b1", g1, model_gnt(1));
            check("rnd_valid_b1", v1, (m_valid[1] != 0));
            check("rnd_starve_b1", s1, model_stv(1));
        end
        check("sb_drained", exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
